ltsm_rx_sb_resp_sequencer: RTL
==============================

// Module: ltsm_rx_sb_resp_sequencer
// PURPOSE
//  Generalised RX-side sideband responder for LTSM substates (TRAINERROR, LINKINIT, PHYRETRAIN...).
//  Walks an ordered table of NUM_STEPS {expected req msg, resp msg} pairs; for each step waits for partner req, sends resp, waits for SB accept.
//  Arbitrates with the TX-side FSM for the shared SB bus; asserts end to LTSM after last step. Sits between SB decoder/encoder and LTSM substate wrapper.
// PARAMETERS
//  SB_MSG_WIDTH    4       width of decoded/encoded SB message code
//  NUM_STEPS       2       number of req/resp pairs walked in order (>=1)
//  TIMEOUT_CYCLES  800000  per-step wait limit (8 ms @100 MHz); used only with RX_SB_RESP_TIMEOUT_EN
// PORTS
//  i_clk              in   1                     clock
//  i_rst_n            in   1                     async active-low reset
//  i_en               in   1                     substate enable from LTSM; low -> abort to IDLE
//  i_req_tbl          in   NUM_STEPS*SB_MSG_WIDTH expected req code per step, step k at [k*W +: W]; static while i_en
//  i_resp_tbl         in   NUM_STEPS*SB_MSG_WIDTH resp code per step, same packing
//  i_rx_msg_valid     in   1                     i_decoded_SB_msg valid strobe
//  i_decoded_SB_msg   in   SB_MSG_WIDTH           decoded partner message
//  i_partner_req      in   1                     req-seen bypass from TX side (counts as match for current step)
//  i_SB_Busy          in   1                     SB encoder busy
//  i_falling_edge_busy in  1                     SB finished consuming current msg
//  i_tx_valid         in   1                     TX-side FSM owns the SB bus this cycle
//  o_encoded_SB_msg   out  SB_MSG_WIDTH           resp code to SB encoder
//  o_valid            out  1                     resp on o_encoded_SB_msg is valid
//  o_step_idx         out  $clog2(NUM_STEPS)+1    current step index
//  o_end              out  1                     all steps done (level, held until i_en low)
//  o_timeout          out  1                     sticky timeout flag (0 constant without macro)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, pending flag 0, step 0, timer 0.
//  - States: IDLE, WAIT_REQ, SEND_RESP, DONE (+TIMEOUT with macro).
//  - IDLE->WAIT_REQ when i_en; clears step, o_end, o_timeout, o_encoded_SB_msg.
//  - WAIT_REQ->SEND_RESP when (i_rx_msg_valid && msg==req_tbl[step]) || i_partner_req; non-matching msgs ignored.
//    Same cycle registers o_encoded_SB_msg<=resp_tbl[step] (1-cycle latency).
//  - Valid: on transition into SEND_RESP set o_valid<=1 if !i_SB_Busy && !i_tx_valid, else set pending.
//    While pending, o_valid<=1 first cycle with !i_tx_valid; pending clears when o_valid=1.
//    i_falling_edge_busy forces o_valid<=0 and has priority over set.
//  - SEND_RESP: on detected falling edge of o_valid (registered copy 1, current 0): step==NUM_STEPS-1 -> DONE, o_end<=1;
//    else step<=step+1, ->WAIT_REQ.
//  - DONE holds o_end=1 until i_en low.
//  - i_en low in any state (incl. mid-send) -> IDLE next cycle; wins over simultaneous req match; o_valid and pending cleared.
//  - Req matching step k+1 arriving while still in SEND_RESP of step k is dropped (partner must retry).
// CONFIGURATION
//  - RX_SB_RESP_TIMEOUT_EN defined: counter ($clog2(TIMEOUT_CYCLES+1) bits) resets on entering WAIT_REQ/SEND_RESP,
//    counts while in them; reaching TIMEOUT_CYCLES-1 -> TIMEOUT, o_timeout<=1 sticky, o_valid<=0; exit only via i_en low.
//    Timeout and req match same cycle: match wins.
//  - Not defined: no counter, no TIMEOUT state, o_timeout tied 0.
// STRUCTURE
//  - Shared package ltsm_sb_pkg: SB message code localparams (e.g. TRAINERROR req=15 resp=14), 8 ms timeout constant.
//  - One sub-module: sb_valid_arbiter (o_valid set/pending/clear logic + falling-edge detect), reusable by TX sequencers.
//  - FSM, step counter, table mux, timer stay in top.
// TESTING
//  - NUM_STEPS=1, tbl {15->14}: i_en, msg 15 valid, SB idle -> o_encoded=14, o_valid next cycle; falling_edge_busy -> o_end=1.
//  - NUM_STEPS=3: reqs 1,3,5 -> resps 2,4,6 in order, o_step_idx 0,1,2; msg 7 in WAIT_REQ ignored.
//  - Match with i_tx_valid=1 for 5 cycles -> o_valid stays 0, rises cycle after i_tx_valid drops.
//  - i_partner_req=1, no rx msg -> resp sent same as decoded match.
//  - i_en dropped while o_valid=1 -> o_valid=0, IDLE next cycle; re-enable -> step 0, o_end=0.
//  - Macro on, TIMEOUT_CYCLES=16, no req -> o_timeout=1 at cycle 16 after WAIT_REQ entry; stays until i_en low.

Source files
------------

// File: rtl/ltsm_sb_pkg.sv
`default_nettype none
// =============================================================================
// ltsm_sb_pkg : shared sideband message codes, timing constants and RX
//               sequencer state encoding for the LTSM substate responders.
// Revision    : 1.0
// =============================================================================
package ltsm_sb_pkg;

   // Sideband message codes as produced by the SB decoder / taken by the encoder
   localparam logic [3:0] SB_TRAINERROR_REQ  = 4'd15;
   localparam logic [3:0] SB_TRAINERROR_RESP = 4'd14;
   localparam logic [3:0] SB_LINKINIT_REQ    = 4'd11;
   localparam logic [3:0] SB_LINKINIT_RESP   = 4'd10;
   localparam logic [3:0] SB_PHYRETRAIN_REQ  = 4'd9;
   localparam logic [3:0] SB_PHYRETRAIN_RESP = 4'd8;

   // 8 ms handshake limit at 100 MHz
   localparam int SB_TIMEOUT_8MS_CYCLES = 800000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_REQ,
      ST_SEND_RESP,
      ST_DONE
`ifdef RX_SB_RESP_TIMEOUT_EN
      ,ST_TIMEOUT
`endif
   } rx_seq_state_e;

endpackage : ltsm_sb_pkg
`default_nettype wire

// File: rtl/sb_valid_arbiter.sv
`default_nettype none
// =============================================================================
// sb_valid_arbiter : owns the SB valid strobe (set / defer / clear against the
//                    TX-side owner and encoder busy) and flags its falling edge.
// Revision         : 1.0
// =============================================================================
module sb_valid_arbiter (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_set,
   input  logic i_busy,
   input  logic i_tx_valid,
   input  logic i_falling_edge_busy,
   output logic o_valid,
   output logic o_fall
);

   logic valid_q, valid_d;
   logic pend_q, pend_d;
   logic valid_prev_q, valid_prev_d;

   always_comb begin
      valid_d = valid_q;
      pend_d  = pend_q;
      if (i_clr) begin
         valid_d = 1'b0;
         pend_d  = 1'b0;
      end else if (i_falling_edge_busy) begin
         // Encoder consumed the message; a coincident new request is deferred
         valid_d = 1'b0;
         if (i_set) begin
            pend_d = 1'b1;
         end
      end else if (i_set) begin
         if (!i_busy && !i_tx_valid) begin
            valid_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end else if (pend_q && !i_tx_valid) begin
         valid_d = 1'b1;
         pend_d  = 1'b0;
      end
   end

   assign valid_prev_d = i_clr ? 1'b0 : valid_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q      <= 1'b0;
         pend_q       <= 1'b0;
         valid_prev_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         pend_q       <= pend_d;
         valid_prev_q <= valid_prev_d;
      end
   end

   assign o_valid = valid_q;
   assign o_fall  = valid_prev_q & ~valid_q;

endmodule : sb_valid_arbiter
`default_nettype wire

// File: rtl/ltsm_rx_sb_resp_sequencer.sv
`default_nettype none
// =============================================================================
// ltsm_rx_sb_resp_sequencer : walks a table of {partner req, local resp} pairs,
//   answering each request on the shared SB bus; RX_SB_RESP_TIMEOUT_EN adds a
//   per-step timeout with a sticky o_timeout flag.
// Revision : 1.0
// =============================================================================
module ltsm_rx_sb_resp_sequencer
   import ltsm_sb_pkg::*;
#(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int NUM_STEPS      = 2,
   parameter int TIMEOUT_CYCLES = SB_TIMEOUT_8MS_CYCLES
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_en,
   input  logic [NUM_STEPS*SB_MSG_WIDTH-1:0] i_req_tbl,
   input  logic [NUM_STEPS*SB_MSG_WIDTH-1:0] i_resp_tbl,
   input  logic                              i_rx_msg_valid,
   input  logic [SB_MSG_WIDTH-1:0]           i_decoded_SB_msg,
   input  logic                              i_partner_req,
   input  logic                              i_SB_Busy,
   input  logic                              i_falling_edge_busy,
   input  logic                              i_tx_valid,
   output logic [SB_MSG_WIDTH-1:0]           o_encoded_SB_msg,
   output logic                              o_valid,
   output logic [$clog2(NUM_STEPS):0]        o_step_idx,
   output logic                              o_end,
   output logic                              o_timeout
);

   localparam int STEP_W = $clog2(NUM_STEPS) + 1;

   rx_seq_state_e             state_q, state_d;
   logic [STEP_W-1:0]         step_q, step_d;
   logic [SB_MSG_WIDTH-1:0]   enc_q, enc_d;
   logic                      end_q, end_d;
   logic [SB_MSG_WIDTH-1:0]   req_cur, resp_cur;
   logic                      req_hit;
   logic                      last_step;
   logic                      resp_set;
   logic                      arb_clr;
   logic                      valid_fall;

   // Table lookup for the current step
   always_comb begin
      req_cur  = '0;
      resp_cur = '0;
      for (int k = 0; k < NUM_STEPS; k++) begin
         if (step_q == STEP_W'(k)) begin
            req_cur  = i_req_tbl[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
            resp_cur = i_resp_tbl[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
         end
      end
   end

   assign req_hit   = (i_rx_msg_valid && (i_decoded_SB_msg == req_cur)) || i_partner_req;
   assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

`ifdef RX_SB_RESP_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             timeout_q, timeout_d;
   logic             tmo_hit;
   logic             in_timed;

   assign in_timed = (state_q == ST_WAIT_REQ) || (state_q == ST_SEND_RESP);
   assign tmo_hit  = in_timed && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

   // Restart on every entry into a timed state, count while staying there
   always_comb begin
      tmr_d = '0;
      if (in_timed && (state_d == state_q)) begin
         tmr_d = tmr_q + 1'b1;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      enc_d    = enc_q;
      end_d    = end_q;
      resp_set = 1'b0;
      arb_clr  = 1'b0;
`ifdef RX_SB_RESP_TIMEOUT_EN
      timeout_d = timeout_q;
`endif
      if (!i_en) begin
         // Abort overrides everything, including a same-cycle request match
         state_d = ST_IDLE;
         step_d  = '0;
         end_d   = 1'b0;
         arb_clr = 1'b1;
`ifdef RX_SB_RESP_TIMEOUT_EN
         timeout_d = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_REQ;
               step_d  = '0;
               end_d   = 1'b0;
               enc_d   = '0;
`ifdef RX_SB_RESP_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
            end
            ST_WAIT_REQ: begin
               if (req_hit) begin
                  state_d  = ST_SEND_RESP;
                  enc_d    = resp_cur;
                  resp_set = 1'b1;
               end
`ifdef RX_SB_RESP_TIMEOUT_EN
               else if (tmo_hit) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
                  arb_clr   = 1'b1;
               end
`endif
            end
            ST_SEND_RESP: begin
               // Requests seen here are not latched; the partner retries
               if (valid_fall) begin
                  if (last_step) begin
                     state_d = ST_DONE;
                     end_d   = 1'b1;
                  end else begin
                     state_d = ST_WAIT_REQ;
                     step_d  = step_q + 1'b1;
                  end
               end
`ifdef RX_SB_RESP_TIMEOUT_EN
               else if (tmo_hit) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
                  arb_clr   = 1'b1;
               end
`endif
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
`ifdef RX_SB_RESP_TIMEOUT_EN
            ST_TIMEOUT: begin
               state_d = ST_TIMEOUT;
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         enc_q   <= '0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         enc_q   <= enc_d;
         end_q   <= end_d;
      end
   end

`ifdef RX_SB_RESP_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   sb_valid_arbiter u_valid_arb (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_clr               (arb_clr),
      .i_set               (resp_set),
      .i_busy              (i_SB_Busy),
      .i_tx_valid          (i_tx_valid),
      .i_falling_edge_busy (i_falling_edge_busy),
      .o_valid             (o_valid),
      .o_fall              (valid_fall)
   );

   assign o_encoded_SB_msg = enc_q;
   assign o_step_idx       = step_q;
   assign o_end            = end_q;

endmodule : ltsm_rx_sb_resp_sequencer
`default_nettype wire
